// File: rtl/level_engine_if.sv
// Bundle that runs between the game controller and the level playfield engine.
// The controller drives the scan and sprite positions, and the engine returns colour and status.
interface level_engine_if;
  logic       active;
  logic       enable;
  logic       frame_tick;
  logic [9:0] col;
  logic [9:0] row;
  logic [9:0] char_pos_x;
  logic [9:0] char_pos_y;
  logic [9:0] bomb_pos_x;
  logic [9:0] bomb_pos_y;
  logic [3:0] b_cnt;
  logic [7:0] VGA_R;
  logic [7:0] VGA_G;
  logic [7:0] VGA_B;
  logic       coll;
  logic       coll_miner;
  logic       death;
  logic       level_done;

  modport master (
    output active, enable, frame_tick, col, row, char_pos_x, char_pos_y,
           bomb_pos_x, bomb_pos_y, b_cnt,
    input  VGA_R, VGA_G, VGA_B, coll, coll_miner, death, level_done
  );

  modport slave (
    input  active, enable, frame_tick, col, row, char_pos_x, char_pos_y,
           bomb_pos_x, bomb_pos_y, b_cnt,
    output VGA_R, VGA_G, VGA_B, coll, coll_miner, death, level_done
  );
endinterface

// File: rtl/level_engine.sv
// Playfield engine for one H.E.R.O. level. It renders walls, sprites and the bomb as registered colour,
// and tracks collisions, a patrolling spider, a breakable wall, and the death/rescue state.
module level_engine #(
  parameter int                     N_WALLS      = 5,
  parameter logic [N_WALLS*40-1:0]  WALL_RECTS   = '0,
  parameter logic [39:0]            BWALL_RECT   = {10'd250, 10'd325, 10'd125, 10'd250},
  parameter int                     H_RES        = 640,
  parameter int                     V_RES        = 480,
  parameter int                     SPIDER_X     = 250,
  parameter int                     SPIDER_Y_MIN = 140,
  parameter int                     SPIDER_Y_MAX = 240,
  parameter int                     SPIDER_DIV   = 4,
  parameter int                     MINER_X      = 550,
  parameter int                     MINER_Y      = 233
) (
  input logic           clk,
  input logic           reset,
  level_engine_if.slave bus
);
  localparam logic [9:0] BW_L = BWALL_RECT[39:30];
  localparam logic [9:0] BW_R = BWALL_RECT[29:20];
  localparam logic [9:0] BW_U = BWALL_RECT[19:10];
  localparam logic [9:0] BW_D = BWALL_RECT[9:0];
  localparam logic [9:0] SP_L = 10'(SPIDER_X - 7);
  localparam logic [9:0] SP_R = 10'(SPIDER_X + 7);
  localparam logic [9:0] MN_L = 10'(MINER_X - 15);
  localparam logic [9:0] MN_R = 10'(MINER_X + 15);
  localparam logic [9:0] MN_U = 10'(MINER_Y - 16);
  localparam logic [9:0] MN_D = 10'(MINER_Y + 16);
  localparam logic [9:0] YMIN = 10'(SPIDER_Y_MIN);
  localparam logic [9:0] YMAX = 10'(SPIDER_Y_MAX);
  localparam logic [9:0] HRES = 10'(H_RES);
  localparam logic [9:0] VRES = 10'(V_RES);
  localparam logic [7:0] DIV_LAST = 8'(SPIDER_DIV - 1);

  typedef enum logic [1:0] {IDLE, PLAY, DEAD, RESCUED} state_t;

  state_t     r_state;
  logic [9:0] r_sp_y;
  logic       r_sp_down, r_sp_alive, r_bw_intact;
  logic [7:0] r_div;
  logic [7:0] r_vga_r, r_vga_g, r_vga_b;
  logic       r_coll, r_coll_miner, r_death, r_level_done;

  function automatic logic ovl(input logic [9:0] al, ar, au, ad, bl, br, bu, bd);
    return (ar >= bl) && (al <= br) && (au <= bd) && (ad >= bu);
  endfunction

  function automatic logic hero_px(input logic [9:0] dx, dy);
    if (dy < 10'd13)      return (dx >= 10'd7) && (dx <= 10'd17);
    else if (dy < 10'd39) return 1'b1;
    else                  return (dx <= 10'd9) || (dx >= 10'd15);
  endfunction

  function automatic logic spider_px(input logic [9:0] dx, dy);
    return !dy[0] || ((dx >= 10'd4) && (dx <= 10'd9));
  endfunction

  function automatic logic miner_px(input logic [9:0] dx, dy);
    if (dy < 10'd10) return (dx >= 10'd10) && (dx <= 10'd19);
    else             return (dx >= 10'd5) && (dx <= 10'd24);
  endfunction

  logic [9:0] w_hl, w_hr, w_hu, w_hd, w_sp_u, w_sp_d;
  logic [9:0] w_bl, w_br, w_bu, w_bd;
  assign w_hl   = bus.char_pos_x - 10'd13;
  assign w_hr   = bus.char_pos_x + 10'd13;
  assign w_hu   = bus.char_pos_y - 10'd28;
  assign w_hd   = bus.char_pos_y + 10'd28;
  assign w_sp_u = r_sp_y - 10'd5;
  assign w_sp_d = r_sp_y + 10'd5;
  assign w_bl   = bus.bomb_pos_x - 10'd20;
  assign w_br   = bus.bomb_pos_x + 10'd20;
  assign w_bu   = bus.bomb_pos_y - 10'd20;
  assign w_bd   = bus.bomb_pos_y + 10'd20;

  logic w_blast, w_blast_bw, w_blast_sp, w_hit_sp, w_miner, w_edge, w_bw_coll;
  assign w_blast    = (bus.b_cnt == 4'd3);
  assign w_blast_bw = w_blast && ovl(w_bl, w_br, w_bu, w_bd, BW_L, BW_R, BW_U, BW_D);
  assign w_blast_sp = w_blast && ovl(w_bl, w_br, w_bu, w_bd, SP_L, SP_R, w_sp_u, w_sp_d);
  // A blast in the same cycle kills the spider before it can kill the hero.
  assign w_hit_sp   = r_sp_alive && !w_blast_sp &&
                      ovl(w_hl, w_hr, w_hu, w_hd, SP_L, SP_R, w_sp_u, w_sp_d);
  assign w_miner    = ovl(w_hl, w_hr, w_hu, w_hd, MN_L, MN_R, MN_U, MN_D);
  assign w_edge     = (w_hl == 10'd0) || (w_hr >= HRES) || (w_hu == 10'd0) || (w_hd >= VRES);
  assign w_bw_coll  = r_bw_intact && ovl(w_hl, w_hr, w_hu, w_hd, BW_L, BW_R, BW_U, BW_D);

  logic w_wall_coll, w_wall_px;
  always_comb begin
    w_wall_coll = 1'b0;
    w_wall_px   = 1'b0;
    for (int unsigned i = 0; i < N_WALLS; i++) begin
      if (ovl(w_hl, w_hr, w_hu, w_hd, WALL_RECTS[40*i+30 +: 10], WALL_RECTS[40*i+20 +: 10],
              WALL_RECTS[40*i+10 +: 10], WALL_RECTS[40*i +: 10]))
        w_wall_coll = 1'b1;
      if ((bus.col > WALL_RECTS[40*i+30 +: 10]) && (bus.col < WALL_RECTS[40*i+20 +: 10]) &&
          (bus.row > WALL_RECTS[40*i+10 +: 10]) && (bus.row < WALL_RECTS[40*i +: 10]))
        w_wall_px = 1'b1;
    end
  end

  // Sprite offsets wrap in 10 bits, so a single upper-bound compare covers both sides of the box.
  logic [9:0] w_h_dx, w_h_dy, w_s_dx, w_s_dy, w_m_dx, w_m_dy, w_b_dx, w_b_dy;
  assign w_h_dx = bus.col - bus.char_pos_x + 10'd12;
  assign w_h_dy = bus.row - bus.char_pos_y + 10'd28;
  assign w_s_dx = bus.col - SP_L;
  assign w_s_dy = bus.row - w_sp_u;
  assign w_m_dx = bus.col - MN_L;
  assign w_m_dy = bus.row - MN_U;
  assign w_b_dx = bus.col - bus.bomb_pos_x + 10'd10;
  assign w_b_dy = bus.row - bus.bomb_pos_y + 10'd10;

  logic w_bw_px, w_hero_on, w_sp_on, w_mn_on, w_bomb_on, w_vis;
  assign w_bw_px   = r_bw_intact && (bus.col > BW_L) && (bus.col < BW_R) &&
                     (bus.row > BW_U) && (bus.row < BW_D);
  assign w_hero_on = (w_h_dx < 10'd25) && (w_h_dy < 10'd57) && hero_px(w_h_dx, w_h_dy);
  assign w_sp_on   = r_sp_alive && (w_s_dx < 10'd14) && (w_s_dy < 10'd10) &&
                     spider_px(w_s_dx, w_s_dy);
  assign w_mn_on   = (w_m_dx < 10'd30) && (w_m_dy < 10'd33) && miner_px(w_m_dx, w_m_dy);
  assign w_bomb_on = ((bus.b_cnt == 4'd1) || (bus.b_cnt == 4'd2)) &&
                     (w_b_dx <= 10'd20) && (w_b_dy <= 10'd20);
  assign w_vis     = bus.enable && bus.active;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vga_r      <= '0;
      r_vga_g      <= '0;
      r_vga_b      <= '0;
      r_coll       <= 1'b0;
      r_coll_miner <= 1'b0;
    end else begin
      r_vga_r      <= w_vis ? ((w_wall_px ? 8'hff : 8'h00) | (w_bw_px ? 8'haf : 8'h00) |
                               (w_hero_on ? 8'hc8 : 8'h00) | (w_sp_on ? 8'hc8 : 8'h00)) : '0;
      r_vga_g      <= (w_vis && w_mn_on) ? 8'hc8 : '0;
      r_vga_b      <= (w_vis && w_bomb_on) ? 8'hff : '0;
      r_coll       <= w_edge || w_wall_coll || w_bw_coll;
      r_coll_miner <= w_miner;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_sp_y       <= YMIN;
      r_sp_down    <= 1'b1;
      r_div        <= '0;
      r_sp_alive   <= 1'b1;
      r_bw_intact  <= 1'b1;
      r_death      <= 1'b0;
      r_level_done <= 1'b0;
    end else begin
      if (r_state != IDLE) begin
        if (w_blast_bw) r_bw_intact <= 1'b0;
        if (w_blast_sp) r_sp_alive  <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          r_sp_y       <= YMIN;
          r_sp_down    <= 1'b1;
          r_div        <= '0;
          r_sp_alive   <= 1'b1;
          r_bw_intact  <= 1'b1;
          r_death      <= 1'b0;
          r_level_done <= 1'b0;
          if (bus.enable) r_state <= PLAY;
        end
        PLAY: begin
          if (bus.frame_tick) begin
            if (r_div == DIV_LAST) begin
              r_div <= '0;
              if (r_sp_down) begin
                r_sp_y <= r_sp_y + 10'd1;
                if (r_sp_y + 10'd1 == YMAX) r_sp_down <= 1'b0;
              end else begin
                r_sp_y <= r_sp_y - 10'd1;
                if (r_sp_y - 10'd1 == YMIN) r_sp_down <= 1'b1;
              end
            end else begin
              r_div <= r_div + 8'd1;
            end
          end
          if (w_hit_sp) begin
            r_state <= DEAD;
            r_death <= 1'b1;
          end else if (r_coll_miner) begin
            r_state      <= RESCUED;
            r_level_done <= 1'b1;
          end
        end
        default: begin
          if (!bus.enable) begin
            r_state      <= IDLE;
            r_death      <= 1'b0;
            r_level_done <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.VGA_R      = r_vga_r;
  assign bus.VGA_G      = r_vga_g;
  assign bus.VGA_B      = r_vga_b;
  assign bus.coll       = r_coll;
  assign bus.coll_miner = r_coll_miner;
  assign bus.death      = r_death;
  assign bus.level_done = r_level_done;
endmodule

// File: tb/tb_level_engine.sv
// Directed bench for level_engine. It uses two walls: {80,200,30,70} and {400,460,300,400}.
// The breakable wall, spider and miner stay at their default geometry.
module tb_level_engine;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  level_engine_if bus ();

  level_engine #(
    .N_WALLS   (2),
    .WALL_RECTS({10'd400, 10'd460, 10'd300, 10'd400, 10'd80, 10'd200, 10'd30, 10'd70})
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hero(input int x, input int y);
    bus.char_pos_x = 10'(x);
    bus.char_pos_y = 10'(y);
  endtask

  task automatic probe(input int c, input int r);
    bus.col = 10'(c);
    bus.row = 10'(r);
  endtask

  task automatic bomb(input int x, input int y, input int cnt);
    bus.bomb_pos_x = 10'(x);
    bus.bomb_pos_y = 10'(y);
    bus.b_cnt      = 4'(cnt);
  endtask

  initial begin
    int s, ey;
    reset = 1'b1;
    bus.active = 1'b1;
    bus.enable = 1'b1;
    bus.frame_tick = 1'b0;
    probe(100, 50);
    hero(300, 200);
    bomb(600, 400, 0);
    step(); step();
    check("rst_R", 16'(bus.VGA_R), 16'h00);
    check("rst_coll", 16'(bus.coll), 16'h0);
    check("rst_coll_miner", 16'(bus.coll_miner), 16'h0);
    check("rst_death", 16'(bus.death), 16'h0);
    check("rst_done", 16'(bus.level_done), 16'h0);

    reset = 1'b0;
    step();
    check("wall_R", 16'(bus.VGA_R), 16'hff);
    check("wall_G", 16'(bus.VGA_G), 16'h00);
    check("wall_B", 16'(bus.VGA_B), 16'h00);
    check("first_death", 16'(bus.death), 16'h0);
    check("first_done", 16'(bus.level_done), 16'h0);
    check("bwall_coll", 16'(bus.coll), 16'h1);

    probe(80, 50);  step(); check("wall_left_excl", 16'(bus.VGA_R), 16'h00);
    probe(81, 50);  step(); check("wall_left_in", 16'(bus.VGA_R), 16'hff);
    probe(199, 69); step(); check("wall_corner_in", 16'(bus.VGA_R), 16'hff);
    probe(100, 70); step(); check("wall_bottom_excl", 16'(bus.VGA_R), 16'h00);
    bus.active = 1'b0;
    probe(100, 50); step(); check("inactive_R", 16'(bus.VGA_R), 16'h00);
    bus.active = 1'b1;

    hero(13, 300);  step(); check("edge_left", 16'(bus.coll), 16'h1);
    hero(14, 300);  step(); check("edge_left_clear", 16'(bus.coll), 16'h0);
    hero(300, 452); step(); check("edge_bottom", 16'(bus.coll), 16'h1);
    hero(300, 451); step(); check("edge_bottom_clear", 16'(bus.coll), 16'h0);
    hero(300, 200);

    // Spider patrol: one pixel every 4 ticks, 140 -> 240 -> 140 over 800 ticks.
    for (int k = 1; k <= 800; k++) begin
      bus.frame_tick = 1'b1;
      step();
      bus.frame_tick = 1'b0;
      s  = k / 4;
      ey = (s <= 100) ? (140 + s) : (340 - s);
      probe(250, ey);     step(); check("spider_centre", 16'(bus.VGA_R), 16'hc8);
      probe(250, ey + 5); step(); check("spider_below", 16'(bus.VGA_R), 16'h00);
      probe(250, ey - 6); step(); check("spider_above", 16'(bus.VGA_R), 16'h00);
    end
    check("patrol_death", 16'(bus.death), 16'h0);

    hero(287, 150);
    probe(290, 200); step();
    check("bwall_touch", 16'(bus.coll), 16'h1);
    check("bwall_R", 16'(bus.VGA_R), 16'haf);
    bomb(270, 150, 1); probe(270, 150); step(); check("bomb_lit1_B", 16'(bus.VGA_B), 16'hff);
    bomb(270, 150, 2); step(); check("bomb_lit2_B", 16'(bus.VGA_B), 16'hff);
    bomb(270, 150, 3); step();
    check("blast_B", 16'(bus.VGA_B), 16'h00);
    check("blast_edge_coll", 16'(bus.coll), 16'h1);
    bomb(270, 150, 0); probe(290, 200); step();
    check("bwall_gone_coll", 16'(bus.coll), 16'h0);
    check("bwall_gone_R", 16'(bus.VGA_R), 16'h00);

    reset = 1'b1; bomb(600, 400, 0); hero(300, 200); step();
    reset = 1'b0; step();
    check("bwall_restored", 16'(bus.coll), 16'h1);

    hero(250, 140); step(); check("death_set", 16'(bus.death), 16'h1);
    check("death_no_done", 16'(bus.level_done), 16'h0);
    step(); check("death_hold", 16'(bus.death), 16'h1);
    hero(450, 100);
    repeat (8) begin
      bus.frame_tick = 1'b1; step(); bus.frame_tick = 1'b0; step();
    end
    probe(250, 135); step(); check("dead_spider_frozen", 16'(bus.VGA_R), 16'hc8);
    check("death_still", 16'(bus.death), 16'h1);
    bus.enable = 1'b0; step(); check("idle_death_clr", 16'(bus.death), 16'h0);

    bus.enable = 1'b1; step();
    hero(550, 233); probe(550, 233); step();
    check("miner_coll", 16'(bus.coll_miner), 16'h1);
    check("miner_G", 16'(bus.VGA_G), 16'hc8);
    check("done_not_yet", 16'(bus.level_done), 16'h0);
    step();
    check("done_set", 16'(bus.level_done), 16'h1);
    check("done_no_death", 16'(bus.death), 16'h0);

    bus.enable = 1'b0; hero(450, 100); step();
    check("idle_done_clr", 16'(bus.level_done), 16'h0);
    bus.enable = 1'b1; step();
    hero(550, 233); step();
    hero(250, 140); step();
    check("prio_death", 16'(bus.death), 16'h1);
    check("prio_no_done", 16'(bus.level_done), 16'h0);

    bus.enable = 1'b0; hero(450, 100); step();
    bus.enable = 1'b1; step();
    hero(250, 140); bomb(250, 140, 3); step();
    check("blast_saves_hero", 16'(bus.death), 16'h0);
    bomb(250, 140, 0); step();
    check("dead_spider_harmless", 16'(bus.death), 16'h0);
    hero(450, 100); probe(250, 140); step();
    check("spider_gone_R", 16'(bus.VGA_R), 16'h00);
    probe(250, 135); step();
    check("spider_gone_top", 16'(bus.VGA_R), 16'h00);
    check("blast_final_death", 16'(bus.death), 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
